// File: rtl/dmem_rmw_ctrl_if.sv
// Core-side request/response bus and RAM port bundle for the data-memory front end.
interface dmem_rmw_ctrl_if #(
    parameter int AW = 12
);
    // Request from the MEM stage
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [31:0]   req_addr_i;
    logic [1:0]    req_size_i;
    logic          req_unsigned_i;
    logic [31:0]   req_wdata_i;
    // Response back to the MEM stage
    logic          rsp_valid_o;
    logic          rsp_err_o;
    logic [31:0]   rsp_rdata_o;
    // Word-wide RAM port
    logic          ram_w_en_o;
    logic [AW-1:0] ram_w_addr_o;
    logic [31:0]   ram_w_data_o;
    logic          ram_r_en_o;
    logic [AW-1:0] ram_r_addr_o;
    logic [31:0]   ram_r_data_i;

    // Controller side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  ram_r_data_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_en_o, ram_r_addr_o
    );

    // Core / RAM side
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        output ram_r_data_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_en_o, ram_r_addr_o
    );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory load/store front end. Byte/half/word requests are turned into
// word-wide RAM accesses; sub-word stores become read-modify-write because the
// RAM has no byte enables. One request is in flight at a time.
module dmem_rmw_ctrl #(
    parameter int AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    dmem_rmw_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        LD_RSP = 3'd2,
        MERGE  = 3'd3,
        WR     = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic          we_r;
    logic [1:0]    size_r;
    logic [1:0]    lane_r;
    logic          uns_r;
    logic [31:0]   sdata_r;
    logic [31:0]   wdata_r;
    logic [AW-1:0] r_addr_r;
    logic [AW-1:0] w_addr_r;

    logic [AW-1:0] idx_s;
    logic          mis_s;
    logic          unused_addr_s;

    // Size 3 is never legal; half needs addr[0]=0; word needs addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = lane[0];
            2'd2:    m = (lane != 2'd0);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Pick the addressed lane of a little-endian word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] d,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    r = {word[31:8], d[7:0]};
                    2'd1:    r = {word[31:16], d[7:0], word[7:0]};
                    2'd2:    r = {word[31:24], d[7:0], word[15:0]};
                    default: r = {d[7:0], word[23:0]};
                endcase
            end
            2'd1:    r = lane[1] ? {d[15:0], word[15:0]} : {word[31:16], d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Address bits above the RAM depth alias and are deliberately ignored.
    assign idx_s         = bus.req_addr_i[AW+1:2];
    assign unused_addr_s = ^bus.req_addr_i[31:AW+2];
    assign mis_s         = misaligned(bus.req_size_i, bus.req_addr_i[1:0]);

    // Request sequencer: latches the request on accept and walks RD/MERGE/WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            we_r     <= 1'b0;
            size_r   <= 2'd0;
            lane_r   <= 2'd0;
            uns_r    <= 1'b0;
            sdata_r  <= 32'd0;
            wdata_r  <= 32'd0;
            r_addr_r <= '0;
            w_addr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        idx_r   <= idx_s;
                        we_r    <= bus.req_we_i;
                        size_r  <= bus.req_size_i;
                        lane_r  <= bus.req_addr_i[1:0];
                        uns_r   <= bus.req_unsigned_i;
                        sdata_r <= bus.req_wdata_i;
                        if (mis_s) begin
                            state_r <= ERR;
                        end else if (!bus.req_we_i || (bus.req_size_i != 2'd2)) begin
                            r_addr_r <= idx_s;
                            state_r  <= RD;
                        end else begin
                            wdata_r  <= bus.req_wdata_i;
                            w_addr_r <= idx_s;
                            state_r  <= WR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    state_r <= we_r ? MERGE : LD_RSP;
                end
                MERGE: begin
                    wdata_r  <= lane_merge(bus.ram_r_data_i, sdata_r, size_r, lane_r);
                    w_addr_r <= idx_r;
                    state_r  <= WR;
                end
                LD_RSP:  state_r <= IDLE;
                WR:      state_r <= IDLE;
                ERR:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Moore output decode; every output is forced low while reset is held.
    always_comb begin
        bus.req_ready_o  = 1'b0;
        bus.rsp_valid_o  = 1'b0;
        bus.rsp_err_o    = 1'b0;
        bus.rsp_rdata_o  = 32'd0;
        bus.ram_w_en_o   = 1'b0;
        bus.ram_r_en_o   = 1'b0;
        bus.ram_w_addr_o = '0;
        bus.ram_r_addr_o = '0;
        bus.ram_w_data_o = 32'd0;
        if (!rst) begin
            bus.ram_w_addr_o = w_addr_r;
            bus.ram_r_addr_o = r_addr_r;
            bus.ram_w_data_o = wdata_r;
            case (state_r)
                IDLE:   bus.req_ready_o = 1'b1;
                RD:     bus.ram_r_en_o  = 1'b1;
                LD_RSP: begin
                    bus.rsp_valid_o = 1'b1;
                    bus.rsp_rdata_o = load_extend(bus.ram_r_data_i, size_r, lane_r, uns_r);
                end
                WR: begin
                    bus.ram_w_en_o  = 1'b1;
                    bus.rsp_valid_o = 1'b1;
                end
                ERR: begin
                    bus.rsp_valid_o = 1'b1;
                    bus.rsp_err_o   = 1'b1;
                end
                default: bus.req_ready_o = 1'b0;
            endcase
        end else begin
            bus.req_ready_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboard bench for dmem_rmw_ctrl: the driver pushes expected responses and
// RAM accesses (with the cycle they must appear in); a monitor pops and compares.
module tb_dmem_rmw_ctrl;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t rsp_q[$];
    ev_t rd_q[$];
    ev_t wr_q[$];

    logic [31:0] mem [0:(2**AW)-1];

    dmem_rmw_ctrl_if #(.AW(AW)) bus ();

    dmem_rmw_ctrl #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with registered read data.
    always @(posedge clk) begin
        if (bus.ram_w_en_o) mem[bus.ram_w_addr_o] <= bus.ram_w_data_o;
        if (bus.ram_r_en_o) bus.ram_r_data_i <= mem[bus.ram_r_addr_o];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT response / RAM access against the queues.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                ev = rsp_q.pop_front();
                check("rsp_missing", 64'(cyc), 64'(ev.cyc));
            end
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                ev = rd_q.pop_front();
                check("rd_missing", 64'(cyc), 64'(ev.cyc));
            end
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                ev = wr_q.pop_front();
                check("wr_missing", 64'(cyc), 64'(ev.cyc));
            end
            if (bus.rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
                end else begin
                    ev = rsp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(ev.cyc));
                    check("rsp_err", 64'(bus.rsp_err_o), 64'(ev.err));
                    check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(ev.data));
                end
            end
            if (bus.ram_r_en_o) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 64'(bus.ram_r_en_o), 64'd0);
                end else begin
                    ev = rd_q.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(ev.cyc));
                    check("rd_addr", 64'(bus.ram_r_addr_o), 64'(ev.addr));
                end
            end
            if (bus.ram_w_en_o) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 64'(bus.ram_w_en_o), 64'd0);
                end else begin
                    ev = wr_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(ev.cyc));
                    check("wr_addr", 64'(bus.ram_w_addr_o), 64'(ev.addr));
                    check("wr_data", 64'(bus.ram_w_data_o), 64'(ev.data));
                end
            end
        end
    end

    // Drive one request; push what the DUT must do. Returns one cycle after accept.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                         input logic expect_done);
        int   guard;
        int   n;
        int   lat;
        ev_t  ev;
        logic [31:0] idx;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = addr;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wd;
        #1;
        guard = 0;
        while (!bus.req_ready_o && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            check("ready_timeout", 64'(bus.req_ready_o), 64'd1);
            bus.req_valid_i = 1'b0;
            return;
        end
        n   = cyc;
        idx = {20'd0, addr[13:2]};
        if (exp_err)                lat = 1;
        else if (!we)               lat = 2;
        else if (size == 2'd2)      lat = 1;
        else                        lat = 3;
        if (!exp_err && (!we || size != 2'd2)) begin
            ev = '{cyc: n + 1, err: 1'b0, addr: idx, data: 32'd0};
            rd_q.push_back(ev);
        end
        if (expect_done) begin
            if (!exp_err && we) begin
                ev = '{cyc: n + lat, err: 1'b0, addr: idx, data: exp_wd};
                wr_q.push_back(ev);
            end
            ev = '{cyc: n + lat, err: exp_err, addr: 32'd0, data: exp_rd};
            rsp_q.push_back(ev);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 32'd0;
        bus.ram_r_data_i   = 32'd0;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_addr_i     = 32'd0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_wdata_i    = 32'd0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 64'(bus.req_ready_o), 64'd0);
            check("rst_enables", 64'({bus.ram_w_en_o, bus.ram_r_en_o, bus.rsp_valid_o}), 64'd0);
            check("rst_data", 64'({bus.rsp_rdata_o, bus.ram_w_data_o}), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(bus.req_ready_o), 64'd1);

        // word store / load
        issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1);
        // byte RMW and byte loads
        issue(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000AA, 1'b0, 32'h0, 32'hAAADBEEF, 1'b1);
        issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFAA, 32'h0, 1'b1);
        issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 1'b0, 32'h000000AA, 32'h0, 1'b1);
        // half RMW and half loads
        issue(1'b1, 32'h12, 2'd1, 1'b0, 32'hFFFF1234, 1'b0, 32'h0, 32'h1234BEEF, 1'b1);
        issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 1'b0, 32'h00001234, 32'h0, 1'b1);
        issue(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFFBEEF, 32'h0, 1'b1);
        issue(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 1'b0, 32'h00001234, 32'h0, 1'b1);
        issue(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 1'b0, 32'h000000BE, 32'h0, 1'b1);
        issue(1'b0, 32'h10, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFEF, 32'h0, 1'b1);
        // address aliasing above the RAM depth
        issue(1'b0, 32'h4010, 2'd2, 1'b0, 32'h0, 1'b0, 32'h1234BEEF, 32'h0, 1'b1);
        // misaligned / illegal requests
        issue(1'b0, 32'h11, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h13, 2'd1, 1'b0, 32'h5555, 1'b1, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h20, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h22, 2'd2, 1'b0, 32'h12345678, 1'b1, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h11, 2'd1, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
        // reset during MERGE of sb 0x10: read happens, no write, no response
        issue(1'b1, 32'h10, 2'd0, 1'b0, 32'h00000055, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h1234BEEF, 32'h0, 1'b1);

        repeat (6) @(negedge clk);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
